// File: rtl/awgn_stats_monitor_if.sv
// Sample stream, thresholds and result bus between the AWGN checker and its consumer.
// The master drives samples/controls and reads results; the slave is the monitor.
interface awgn_stats_monitor_if #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 10
);
    logic                  start;
    logic [DATA_W-1:0]     sample_in;
    logic                  sample_valid;
    logic [DATA_W-1:0]     thr1;
    logic [DATA_W-1:0]     thr2;
    logic [DATA_W-1:0]     thr3;
    logic                  result_ack;
    logic                  busy;
    logic                  done;
    logic [DATA_W-1:0]     mean_out;
    logic [2*DATA_W-1:0]   power_out;
    logic [LOG2_N:0]       cnt1_out;
    logic [LOG2_N:0]       cnt2_out;
    logic [LOG2_N:0]       cnt3_out;

    modport master (
        output start, sample_in, sample_valid, thr1, thr2, thr3, result_ack,
        input  busy, done, mean_out, power_out, cnt1_out, cnt2_out, cnt3_out
    );

    modport slave (
        input  start, sample_in, sample_valid, thr1, thr2, thr3, result_ack,
        output busy, done, mean_out, power_out, cnt1_out, cnt2_out, cnt3_out
    );
endinterface

// File: rtl/awgn_stats_monitor.sv
// Window statistics of the AWGN stream: mean, mean power and threshold exceedance counts
// over 2^LOG2_N accepted samples, held for firmware until acknowledged or restarted.
//
// state   | meaning
// S_IDLE  | waiting for start, results held
// S_ACCUM | accumulating valid samples until N are taken
// S_FINAL | one cycle: scale accumulators into result registers
// S_DONE  | results valid; start re-arms, result_ack returns to idle
module awgn_stats_monitor #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 10
) (
    input  logic                clock,
    input  logic                reset,
    awgn_stats_monitor_if.slave bus
);
    localparam int SUM_W = DATA_W + LOG2_N;
    localparam int SQ_W  = 2*DATA_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((64'd1 << LOG2_N) - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [SQ_W-1:0]         sumsq_q, sumsq_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [DATA_W-1:0]       mean_q, mean_d;
    logic [2*DATA_W-1:0]     power_q, power_d;
    logic [CNT_W-1:0]        r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;

    logic [DATA_W:0]         sext;
    logic [DATA_W:0]         mag;
    logic signed [2*DATA_W-1:0] sx;
    logic signed [2*DATA_W-1:0] sq;
    logic                    gt1, gt2, gt3;

    always_comb begin
        sext = {bus.sample_in[DATA_W-1], bus.sample_in};
        // one extra bit so the most negative input has a representable magnitude
        mag  = sext[DATA_W] ? (~sext + 1'b1) : sext;
        sx   = {{DATA_W{bus.sample_in[DATA_W-1]}}, bus.sample_in};
        sq   = sx * sx;
        gt1  = mag > {1'b0, bus.thr1};
        gt2  = mag > {1'b0, bus.thr2};
        gt3  = mag > {1'b0, bus.thr3};

        state_d = state_q;
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        count_d = count_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        c3_d    = c3_q;
        mean_d  = mean_q;
        power_d = power_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        r3_d    = r3_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_ACCUM;
                    sum_d   = '0;
                    sumsq_d = '0;
                    count_d = '0;
                    c1_d    = '0;
                    c2_d    = '0;
                    c3_d    = '0;
                end else if (state_q == S_DONE && bus.result_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (bus.sample_valid) begin
                    sum_d   = sum_q + {{LOG2_N{bus.sample_in[DATA_W-1]}}, bus.sample_in};
                    sumsq_d = sumsq_q + {{LOG2_N{1'b0}}, sq};
                    c1_d    = c1_q + {{LOG2_N{1'b0}}, gt1};
                    c2_d    = c2_q + {{LOG2_N{1'b0}}, gt2};
                    c3_d    = c3_q + {{LOG2_N{1'b0}}, gt3};
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_IDX) state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                // dropping the low LOG2_N bits of the signed sum is a floor divide
                mean_d  = sum_q[SUM_W-1:LOG2_N];
                power_d = sumsq_q[SQ_W-1:LOG2_N];
                r1_d    = c1_q;
                r2_d    = c2_q;
                r3_d    = c3_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            sumsq_q <= '0;
            count_q <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            c3_q    <= '0;
            mean_q  <= '0;
            power_q <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
            count_q <= count_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
            mean_q  <= mean_d;
            power_q <= power_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
        end
    end

    assign bus.busy      = (state_q == S_ACCUM) || (state_q == S_FINAL);
    assign bus.done      = (state_q == S_DONE);
    assign bus.mean_out  = mean_q;
    assign bus.power_out = power_q;
    assign bus.cnt1_out  = r1_q;
    assign bus.cnt2_out  = r2_q;
    assign bus.cnt3_out  = r3_q;
endmodule

// File: tb/tb_awgn_stats_monitor.sv
// Bench for awgn_stats_monitor with 4-sample windows; expectations come from an
// arithmetic model of mean, mean power and threshold counts over the sample list.
module tb_awgn_stats_monitor;
    localparam int DW = 16;
    localparam int LN = 2;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    awgn_stats_monitor_if #(.DATA_W(DW), .LOG2_N(LN)) bus ();

    awgn_stats_monitor #(.DATA_W(DW), .LOG2_N(LN)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    int smp [N];
    int th1 [N];
    int th2 [N];
    int th3 [N];

    logic [15:0] e_mean;
    logic [31:0] e_pow;
    logic [2:0]  e_c1, e_c2, e_c3;

    function automatic void model();
        longint s = 0;
        longint sq = 0;
        longint m, p, a;
        int c1 = 0, c2 = 0, c3 = 0;
        for (int i = 0; i < N; i++) begin
            longint x = longint'(smp[i]);
            s  += x;
            sq += x * x;
            a = (x < 0) ? -x : x;
            if (a > th1[i]) c1++;
            if (a > th2[i]) c2++;
            if (a > th3[i]) c3++;
        end
        m = s / N;
        if (s < 0 && (s % N) != 0) m = m - 1;
        p = sq / N;
        e_mean = m[15:0];
        e_pow  = p[31:0];
        e_c1   = c1[2:0];
        e_c2   = c2[2:0];
        e_c3   = c3[2:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input int gap, input bit skip_start, input bit valid_on_start,
                              input bit restart_mid);
        int g;
        if (!skip_start) begin
            bus.start        = 1'b1;
            bus.sample_valid = valid_on_start;
            bus.sample_in    = 16'($urandom);
            tick();
            bus.start        = 1'b0;
            bus.sample_valid = 1'b0;
        end
        model();
        for (int i = 0; i < N; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            repeat (g) begin
                bus.sample_valid = 1'b0;
                bus.sample_in    = 16'($urandom);
                bus.thr1         = 16'($urandom);
                tick();
                checks++;
                if (bus.busy !== 1'b1 || bus.done !== 1'b0)
                    $display("FAIL gap_flags busy=%b done=%b exp busy=1 done=0", bus.busy, bus.done);
                if (bus.busy !== 1'b1 || bus.done !== 1'b0) errors++;
            end
            bus.sample_valid = 1'b1;
            bus.sample_in    = smp[i][15:0];
            bus.thr1         = th1[i][15:0];
            bus.thr2         = th2[i][15:0];
            bus.thr3         = th3[i][15:0];
            bus.start        = restart_mid && (i == 2);
            tick();
            bus.start        = 1'b0;
            bus.sample_valid = 1'b0;
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL accum_flags idx=%0d busy=%b done=%b exp busy=1 done=0", i, bus.busy, bus.done);
            end
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_latency done=%b busy=%b exp done=1 busy=0", bus.done, bus.busy);
        end
        checks++;
        if (bus.mean_out !== e_mean) begin
            errors++;
            $display("FAIL mean got=%h exp=%h", bus.mean_out, e_mean);
        end
        checks++;
        if (bus.power_out !== e_pow) begin
            errors++;
            $display("FAIL power got=%h exp=%h", bus.power_out, e_pow);
        end
        checks++;
        if (bus.cnt1_out !== e_c1 || bus.cnt2_out !== e_c2 || bus.cnt3_out !== e_c3) begin
            errors++;
            $display("FAIL counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", bus.cnt1_out, bus.cnt2_out,
                     bus.cnt3_out, e_c1, e_c2, e_c3);
        end
    endtask

    task automatic ack_window();
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle done=%b busy=%b exp 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic set_thr(input int t1, input int t2, input int t3);
        for (int i = 0; i < N; i++) begin
            th1[i] = t1;
            th2[i] = t2;
            th3[i] = t3;
        end
    endtask

    task automatic random_samples();
        logic signed [15:0] r;
        int sh;
        for (int i = 0; i < N; i++) begin
            r = 16'($urandom);
            sh = int'($urandom_range(0, 12));
            r = r >>> sh;
            smp[i] = int'(r);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mean_out !== 16'h0 ||
            bus.power_out !== 32'h0 || bus.cnt1_out !== 3'd0 || bus.cnt2_out !== 3'd0 ||
            bus.cnt3_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b mean=%h pow=%h exp all zero",
                     bus.busy, bus.done, bus.mean_out, bus.power_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        smp[0] = 4; smp[1] = -4; smp[2] = 8; smp[3] = -8;
        set_thr(5, 7, 9);
        run_window(0, 1'b0, 1'b0, 1'b0);
        ack_window();
    endtask

    task automatic test_most_negative();
        for (int i = 0; i < N; i++) smp[i] = -32768;
        set_thr(32'h7FFF, 32'h7FFF, 32'h7FFF);
        run_window(0, 1'b0, 1'b0, 1'b0);
        ack_window();
    endtask

    task automatic test_gaps();
        smp[0] = -1; smp[1] = 0; smp[2] = 0; smp[3] = 0;
        set_thr(0, 0, 0);
        run_window(3, 1'b0, 1'b0, 1'b0);
        ack_window();
    endtask

    task automatic test_start_cycle_valid();
        random_samples();
        set_thr(100, 1000, 5000);
        run_window(0, 1'b0, 1'b1, 1'b0);
        ack_window();
    endtask

    task automatic test_restart_ignored();
        random_samples();
        set_thr(50, 500, 3000);
        run_window(1, 1'b0, 1'b0, 1'b1);
        ack_window();
    endtask

    task automatic test_start_and_ack();
        random_samples();
        set_thr(10, 200, 2000);
        run_window(0, 1'b0, 1'b0, 1'b0);
        bus.start      = 1'b1;
        bus.result_ack = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.result_ack = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_beats_ack done=%b busy=%b exp done=0 busy=1", bus.done, bus.busy);
        end
        random_samples();
        run_window(0, 1'b1, 1'b0, 1'b0);
        ack_window();
    endtask

    task automatic test_abort_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) begin
            bus.sample_valid = 1'b1;
            bus.sample_in    = 16'h1234;
            tick();
        end
        bus.sample_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mean_out !== 16'h0 ||
            bus.power_out !== 32'h0 || bus.cnt1_out !== 3'd0 || bus.cnt2_out !== 3'd0 ||
            bus.cnt3_out !== 3'd0) begin
            errors++;
            $display("FAIL abort_reset busy=%b done=%b mean=%h pow=%h exp all zero",
                     bus.busy, bus.done, bus.mean_out, bus.power_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < N; i++) smp[i] = 2;
        set_thr(1, 2, 3);
        run_window(0, 1'b0, 1'b0, 1'b0);
        ack_window();
    endtask

    task automatic test_done_hold();
        random_samples();
        set_thr(20, 300, 4000);
        run_window(-1, 1'b0, 1'b0, 1'b0);
        repeat (20) begin
            bus.sample_valid = ~bus.sample_valid;
            bus.sample_in    = 16'($urandom);
            bus.thr1         = 16'($urandom);
            tick();
            checks++;
            if (bus.done !== 1'b1 || bus.mean_out !== e_mean || bus.power_out !== e_pow ||
                bus.cnt1_out !== e_c1 || bus.cnt2_out !== e_c2 || bus.cnt3_out !== e_c3) begin
                errors++;
                $display("FAIL done_hold done=%b mean=%h pow=%h exp done=1 mean=%h pow=%h",
                         bus.done, bus.mean_out, bus.power_out, e_mean, e_pow);
            end
        end
        bus.sample_valid = 1'b0;
        ack_window();
        checks++;
        if (bus.mean_out !== e_mean) begin
            errors++;
            $display("FAIL mean_after_ack got=%h exp=%h", bus.mean_out, e_mean);
        end
    endtask

    task automatic test_random();
        for (int w = 0; w < 20; w++) begin
            random_samples();
            for (int i = 0; i < N; i++) begin
                th1[i] = int'($urandom_range(0, 255));
                th2[i] = int'($urandom_range(0, 4095));
                th3[i] = int'($urandom_range(0, 65535));
            end
            run_window(-1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) ack_window();
        end
        ack_window();
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.thr1         = '0;
        bus.thr2         = '0;
        bus.thr3         = '0;
        bus.result_ack   = 1'b0;
        test_reset();
        test_basic();
        test_most_negative();
        test_gaps();
        test_start_cycle_valid();
        test_restart_ignored();
        test_start_and_ack();
        test_done_hold();
        test_abort_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
